// File: rtl/gate_pkg.sv
// Shared types and constants for the parking-gate sensor decoder.
package gate_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EN1,
        EN2,
        EN3,
        EX1,
        EX2,
        EX3,
        FAULT
    } gate_state_t;

    localparam logic [1:0] SENS_OPEN = 2'b00;

endpackage

// File: rtl/sensor_filter.sv
// Two-flop synchroniser followed by a debounce filter for one photo sensor.
module sensor_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic Reset,
    input  logic raw,
    output logic filt
);

    logic       sync1_q;
    logic       sync2_q;
    logic       filt_q;
    logic [7:0] cnt_q;

    // Filtered value follows only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
                cnt_q <= 8'd0;
            end else if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
                filt_q <= sync2_q;
                cnt_q  <= 8'd0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/gate_sensor_decoder.sv
// Turns the outer/inner gate sensors into single-cycle car enter/exit pulses.
module gate_sensor_decoder
    import gate_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic Reset,
    input  logic sa,
    input  logic sb,
    output logic cen,
    output logic cex,
    output logic busy,
    output logic fault
);

    logic        a_filt;
    logic        b_filt;
    logic [1:0]  ab;
    gate_state_t state_q, state_d;
    logic        cen_q, cen_d;
    logic        cex_q, cex_d;
    logic        fault_q, fault_d;

    sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter_a (
        .clk   (clk),
        .Reset (Reset),
        .raw   (sa),
        .filt  (a_filt)
    );

    sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter_b (
        .clk   (clk),
        .Reset (Reset),
        .raw   (sb),
        .filt  (b_filt)
    );

    assign ab = {a_filt, b_filt};

    always_comb begin
        state_d = state_q;
        cen_d   = 1'b0;
        cex_d   = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ab == 2'b10) state_d = EN1;
                else if (ab == 2'b01) state_d = EX1;
                else if (ab == 2'b11) begin state_d = FAULT; fault_d = 1'b1; end
            end
            EN1: begin
                if (ab == 2'b11) state_d = EN2;
                else if (ab == SENS_OPEN) state_d = IDLE;
                else if (ab == 2'b01) begin state_d = FAULT; fault_d = 1'b1; end
            end
            EN2: begin
                if (ab == 2'b01) state_d = EN3;
                else if (ab == 2'b10) state_d = EN1;
                else if (ab == SENS_OPEN) begin state_d = FAULT; fault_d = 1'b1; end
            end
            EN3: begin
                if (ab == SENS_OPEN) begin state_d = IDLE; cen_d = 1'b1; end
                else if (ab == 2'b11) state_d = EN2;
                else if (ab == 2'b10) begin state_d = FAULT; fault_d = 1'b1; end
            end
            EX1: begin
                if (ab == 2'b11) state_d = EX2;
                else if (ab == SENS_OPEN) state_d = IDLE;
                else if (ab == 2'b10) begin state_d = FAULT; fault_d = 1'b1; end
            end
            EX2: begin
                if (ab == 2'b10) state_d = EX3;
                else if (ab == 2'b01) state_d = EX1;
                else if (ab == SENS_OPEN) begin state_d = FAULT; fault_d = 1'b1; end
            end
            EX3: begin
                if (ab == SENS_OPEN) begin state_d = IDLE; cex_d = 1'b1; end
                else if (ab == 2'b11) state_d = EX2;
                else if (ab == 2'b01) begin state_d = FAULT; fault_d = 1'b1; end
            end
            FAULT: begin
                // Latched until the gate is completely clear; no pulse on recovery.
                if (ab == SENS_OPEN) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cen_q   <= 1'b0;
            cex_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cen_q   <= cen_d;
            cex_q   <= cex_d;
            fault_q <= fault_d;
        end
    end

    assign cen   = cen_q;
    assign cex   = cex_q;
    assign fault = fault_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Scoreboard bench for gate_sensor_decoder with DEBOUNCE_CYCLES = 4.
module tb_gate_sensor_decoder;

    localparam logic [2:0] K_CEN = 3'b100;
    localparam logic [2:0] K_CEX = 3'b010;
    localparam logic [2:0] K_FLT = 3'b001;
    // Raw driven after edge n is sampled at n+1; pulse registered at n+1+2+DEBOUNCE_CYCLES.
    localparam int LAT = 7;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic Reset;
    logic sa;
    logic sb;
    logic cen;
    logic cex;
    logic busy;
    logic fault;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    gate_sensor_decoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .Reset (Reset),
        .sa    (sa),
        .sb    (sb),
        .cen   (cen),
        .cex   (cex),
        .busy  (busy),
        .fault (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive a raw pair, optionally expect a pulse LAT cycles later, then hold.
    task automatic step(input logic a, input logic b, input int hold, input logic [2:0] kind);
        exp_t e;
        sa = a;
        sb = b;
        if (kind != 3'b000) begin
            e.kind = kind;
            e.cyc  = cyc + LAT;
            exp_q.push_back(e);
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic check_busy(input string name, input logic expv);
        total++;
        if (busy !== expv) begin
            bad++;
            $display("FAIL %s: busy=%0b required=%0b (cycle %0d)", name, busy, expv, cyc);
        end
    endtask

    task automatic check_quiet(input string name);
        total++;
        if ({cen, cex, fault, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL %s: cen,cex,fault,busy=%b required=0000", name,
                     {cen, cex, fault, busy});
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cen || cex || fault) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: cen,cex,fault=%b at cycle %0d, required none",
                             {cen, cex, fault}, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({cen, cex, fault} !== e.kind || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL pulse: cen,cex,fault=%b at cycle %0d, required %b at cycle %0d",
                                 {cen, cex, fault}, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        Reset = 1'b1;
        sa    = 1'b0;
        sb    = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        Reset = 1'b0;
        step(0, 0, 5, 3'b000);

        // Entry
        step(1, 0, 10, 3'b000);
        check_busy("entry_en1", 1'b1);
        step(1, 1, 10, 3'b000);
        step(0, 1, 10, 3'b000);
        check_busy("entry_en3", 1'b1);
        step(0, 0, 10, K_CEN);
        check_busy("entry_done", 1'b0);

        // Exit
        step(0, 1, 10, 3'b000);
        check_busy("exit_ex1", 1'b1);
        step(1, 1, 10, 3'b000);
        step(1, 0, 10, 3'b000);
        step(0, 0, 10, K_CEX);
        check_busy("exit_done", 1'b0);

        // Abort
        step(1, 0, 10, 3'b000);
        check_busy("abort_en1", 1'b1);
        step(0, 0, 10, 3'b000);
        check_busy("abort_idle", 1'b0);

        // Backtrack
        step(1, 0, 10, 3'b000);
        step(1, 1, 10, 3'b000);
        step(1, 0, 10, 3'b000);
        check_busy("backtrack_en1", 1'b1);
        step(1, 1, 10, 3'b000);
        step(0, 1, 10, 3'b000);
        step(0, 0, 10, K_CEN);
        check_busy("backtrack_done", 1'b0);

        // Glitches: 3 cycles is filtered out, 4 cycles reaches EN1 then aborts
        step(1, 0, 3, 3'b000);
        step(0, 0, 10, 3'b000);
        check_busy("glitch3", 1'b0);
        step(1, 0, 4, 3'b000);
        step(0, 0, 4, 3'b000);
        check_busy("glitch4_en1", 1'b1);
        step(0, 0, 10, 3'b000);
        check_busy("glitch4_idle", 1'b0);

        // Illegal 11 from IDLE, recovery, then a legal entry
        step(1, 1, 10, K_FLT);
        check_busy("illegal_fault", 1'b1);
        step(0, 0, 10, 3'b000);
        check_busy("illegal_clear", 1'b0);
        step(1, 0, 10, 3'b000);
        step(1, 1, 10, 3'b000);
        step(0, 1, 10, 3'b000);
        step(0, 0, 10, K_CEN);

        // Reset while in EN2
        step(1, 0, 10, 3'b000);
        step(1, 1, 10, 3'b000);
        check_busy("rst_en2", 1'b1);
        Reset = 1'b1;
        @(negedge clk);
        check_quiet("rst_mid");
        Reset = 1'b0;
        step(0, 0, 15, 3'b000);
        check_busy("rst_after", 1'b0);

        // Back-to-back entries
        step(1, 0, 10, 3'b000);
        step(1, 1, 10, 3'b000);
        step(0, 1, 10, 3'b000);
        step(0, 0, 5, K_CEN);
        step(1, 0, 10, 3'b000);
        step(1, 1, 10, 3'b000);
        step(0, 1, 10, 3'b000);
        step(0, 0, 10, K_CEN);
        check_busy("b2b_done", 1'b0);

        repeat (20) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses: outstanding=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
